// File: rtl/vga_port_arbiter_pkg.sv
// Shared definitions for the VGA memory-port arbiter: FSM state encodings and
// the vga_ctrl / vga_stat bit positions.
package vga_port_arbiter_pkg;

  localparam int unsigned VGA_WRITE_PIN = 0;
  localparam int unsigned VGA_READ_PIN  = 1;
  localparam int unsigned VGA_ACK       = 0;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vga_port_arbiter_rr_pick.sv
// Combinational two-way round-robin picker: when both request, the one that
// did not win last time gets the grant; a lone requester always wins.
module vga_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/vga_port_arbiter.sv
// Round-robin arbiter and four-phase handshake sequencer for the VGA memory port.
// Optional ack watchdog enabled by defining VGA_ARB_TIMEOUT_EN.
module vga_port_arbiter
  import vga_port_arbiter_pkg::*;
#(
  parameter int unsigned word_width     = 32,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic                  r1_req,
  input  logic                  r0_we,
  input  logic                  r1_we,
  input  logic [word_width-1:0] r0_addr,
  input  logic [word_width-1:0] r1_addr,
  input  logic [word_width-1:0] r0_wdata,
  input  logic [word_width-1:0] r1_wdata,
  output logic [word_width-1:0] r0_rdata,
  output logic [word_width-1:0] r1_rdata,
  output logic                  r0_done,
  output logic                  r1_done,
  output logic                  err,
  output logic                  busy,
  input  logic [word_width-1:0] vga_stat,
  output logic [word_width-1:0] vga_ctrl,
  output logic [word_width-1:0] addr,
  output logic [word_width-1:0] data_out,
  input  logic [word_width-1:0] data_in
);

  arb_state_e            state, state_n;
  logic                  last, last_n;
  logic                  win, win_n;
  logic                  is_read, is_read_n;
  logic [word_width-1:0] ctrl_n, addr_n, dout_n, rd0_n, rd1_n;
  logic                  done0_n, done1_n, busy_n;
  logic                  pick_grant, pick_valid;
  logic                  ack;
  logic                  unused_stat;

  assign ack         = vga_stat[VGA_ACK];
  assign unused_stat = ^vga_stat;

  vga_rr_pick u_pick (
    .req   ({r1_req, r0_req}),
    .last  (last),
    .grant (pick_grant),
    .valid (pick_valid)
  );

`ifdef VGA_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(timeout_cycles + 1);
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             aborted, aborted_n;
  logic             err_q, err_n;
  logic             timed_out;

  assign timed_out = (cnt == CNT_W'(timeout_cycles - 1));
  assign err       = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    last_n    = last;
    win_n     = win;
    is_read_n = is_read;
    ctrl_n    = vga_ctrl;
    addr_n    = addr;
    dout_n    = data_out;
    rd0_n     = r0_rdata;
    rd1_n     = r1_rdata;
    done0_n   = 1'b0;
    done1_n   = 1'b0;
`ifdef VGA_ARB_TIMEOUT_EN
    aborted_n = aborted;
    err_n     = 1'b0;
`endif
    case (state)
      ARB_IDLE: begin
        if (!ack && pick_valid) begin
          win_n     = pick_grant;
          is_read_n = pick_grant ? ~r1_we : ~r0_we;
          addr_n    = pick_grant ? r1_addr : r0_addr;
          ctrl_n    = '0;
          if (pick_grant ? r1_we : r0_we) begin
            dout_n                = pick_grant ? r1_wdata : r0_wdata;
            ctrl_n[VGA_WRITE_PIN] = 1'b1;
          end else begin
            ctrl_n[VGA_READ_PIN] = 1'b1;
          end
`ifdef VGA_ARB_TIMEOUT_EN
          aborted_n = 1'b0;
`endif
          state_n = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (ack) begin
          if (is_read) begin
            if (win) rd1_n = data_in;
            else     rd0_n = data_in;
          end
          ctrl_n  = '0;
          state_n = ARB_RELEASE;
        end
`ifdef VGA_ARB_TIMEOUT_EN
        else if (timed_out) begin
          ctrl_n    = '0;
          aborted_n = 1'b1;
          state_n   = ARB_RELEASE;
        end
`endif
      end
      ARB_RELEASE: begin
        if (!ack) begin
          done0_n = ~win;
          done1_n = win;
          last_n  = win;
          state_n = ARB_IDLE;
`ifdef VGA_ARB_TIMEOUT_EN
          err_n = aborted;
`endif
        end
`ifdef VGA_ARB_TIMEOUT_EN
        else if (timed_out) begin
          done0_n = ~win;
          done1_n = win;
          err_n   = 1'b1;
          last_n  = win;
          state_n = ARB_IDLE;
        end
`endif
      end
      default: state_n = ARB_IDLE;
    endcase
    busy_n = (state_n != ARB_IDLE);
`ifdef VGA_ARB_TIMEOUT_EN
    // Watchdog restarts on every state change and idles at zero
    cnt_n = (state_n == state && state != ARB_IDLE) ? cnt + CNT_W'(1) : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      last     <= 1'b1;
      win      <= 1'b0;
      is_read  <= 1'b0;
      vga_ctrl <= '0;
      addr     <= '0;
      data_out <= '0;
      r0_rdata <= '0;
      r1_rdata <= '0;
      r0_done  <= 1'b0;
      r1_done  <= 1'b0;
      busy     <= 1'b0;
`ifdef VGA_ARB_TIMEOUT_EN
      cnt      <= '0;
      aborted  <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      last     <= last_n;
      win      <= win_n;
      is_read  <= is_read_n;
      vga_ctrl <= ctrl_n;
      addr     <= addr_n;
      data_out <= dout_n;
      r0_rdata <= rd0_n;
      r1_rdata <= rd1_n;
      r0_done  <= done0_n;
      r1_done  <= done1_n;
      busy     <= busy_n;
`ifdef VGA_ARB_TIMEOUT_EN
      cnt      <= cnt_n;
      aborted  <= aborted_n;
      err_q    <= err_n;
`endif
    end
  end

endmodule
